// File: rtl/operand_collector_array_if.sv
// Issue / register-bank / dispatch signal bundle for the operand collector array.
// The master side is the environment (issue unit, banks, execution stage).
interface operand_collector_array_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ROW_W  = 3
);
   logic                  alloc_valid;
   logic [1:0]            alloc_ocid;
   logic [31:0]           alloc_instr;
   logic [2:0]            alloc_warp;
   logic                  alloc_two_op;
   logic [1:0]            alloc_bank_a;
   logic [1:0]            alloc_bank_b;
   logic [ROW_W-1:0]      alloc_row_a;
   logic [ROW_W-1:0]      alloc_row_b;
   logic                  alloc_err;
   logic [3:0]            oc_empty;

   logic [3:0]            bank_rd_en;
   logic [4*ROW_W-1:0]    bank_rd_row;
   logic [4*DATA_W-1:0]   bank_rd_data;

   logic                  disp_valid;
   logic                  disp_ready;
   logic [1:0]            disp_ocid;
   logic [31:0]           disp_instr;
   logic [2:0]            disp_warp;
   logic [DATA_W-1:0]     disp_op_a;
   logic [DATA_W-1:0]     disp_op_b;

   modport master (
      output alloc_valid, alloc_ocid, alloc_instr, alloc_warp, alloc_two_op,
      output alloc_bank_a, alloc_bank_b, alloc_row_a, alloc_row_b,
      output bank_rd_data, disp_ready,
      input  alloc_err, oc_empty, bank_rd_en, bank_rd_row,
      input  disp_valid, disp_ocid, disp_instr, disp_warp, disp_op_a, disp_op_b
   );

   modport slave (
      input  alloc_valid, alloc_ocid, alloc_instr, alloc_warp, alloc_two_op,
      input  alloc_bank_a, alloc_bank_b, alloc_row_a, alloc_row_b,
      input  bank_rd_data, disp_ready,
      output alloc_err, oc_empty, bank_rd_en, bank_rd_row,
      output disp_valid, disp_ocid, disp_instr, disp_warp, disp_op_a, disp_op_b
   );
endinterface

// File: rtl/operand_collector_array.sv
// Four operand collectors fed by four round-robin arbitrated register banks; complete
// entries are dispatched round-robin over a valid/ready handshake.
module operand_collector_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ROW_W  = 3
) (
   input logic                      clk,
   input logic                      rst,
   operand_collector_array_if.slave bus
);

   typedef enum logic [1:0] {StEmpty, StCollect, StReady} oc_state_e;

   // Entry state
   oc_state_e         st_q      [4];
   oc_state_e         st_d      [4];
   logic [31:0]       instr_q   [4];
   logic [31:0]       instr_d   [4];
   logic [2:0]        warp_q    [4];
   logic [2:0]        warp_d    [4];

   // Operand slots, index = ocid*2 + (operand b)
   logic [7:0]        needed_q, needed_d;
   logic [7:0]        in_flight_q, in_flight_d;
   logic [7:0]        captured_q, captured_d;
   logic [1:0]        bank_q    [8];
   logic [1:0]        bank_d    [8];
   logic [ROW_W-1:0]  row_q     [8];
   logic [ROW_W-1:0]  row_d     [8];
   logic [DATA_W-1:0] opnd_q    [8];
   logic [DATA_W-1:0] opnd_d    [8];

   // Bank arbitration and return tags
   logic [2:0]        arb_ptr_q [4];
   logic [2:0]        arb_ptr_d [4];
   logic [3:0]        tag_vld_q, tag_vld_d;
   logic [2:0]        tag_q     [4];
   logic [2:0]        tag_d     [4];

   // Dispatch
   logic [1:0]        disp_ptr_q, disp_ptr_d;
   logic              lock_q, lock_d;
   logic [1:0]        lock_id_q, lock_id_d;
   logic              alloc_err_q, alloc_err_d;

   logic [7:0]        req       [4];
   logic [3:0]        gnt_vld;
   logic [2:0]        gnt_idx   [4];
   logic [3:0]        rdy_vec;
   logic              sel_vld;
   logic [1:0]        sel;
   logic              hs;
   logic [2:0]        slot_a, slot_b;

   assign slot_a = {bus.alloc_ocid, 1'b0};
   assign slot_b = {bus.alloc_ocid, 1'b1};

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         req[k] = '0;
         for (int r = 0; r < 8; r++) begin
            req[k][r] = needed_q[r] & ~in_flight_q[r] & ~captured_q[r] & (bank_q[r] == 2'(k));
         end
      end
   end

   // Scan from the far end so the requester closest to the pointer is kept last.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         gnt_vld[k] = 1'b0;
         gnt_idx[k] = '0;
         for (int i = 7; i >= 0; i--) begin
            if (req[k][3'(arb_ptr_q[k] + 3'(i))]) begin
               gnt_vld[k] = 1'b1;
               gnt_idx[k] = 3'(arb_ptr_q[k] + 3'(i));
            end
         end
      end
   end

   assign bus.bank_rd_en = gnt_vld;

   always_comb begin
      bus.bank_rd_row = '0;
      for (int k = 0; k < 4; k++) begin
         if (gnt_vld[k]) begin
            bus.bank_rd_row[k*ROW_W +: ROW_W] = row_q[gnt_idx[k]];
         end
      end
   end

   // A locked entry keeps the dispatch port until its handshake completes.
   always_comb begin
      for (int o = 0; o < 4; o++) begin
         rdy_vec[o] = (st_q[o] == StReady);
      end
      sel_vld = 1'b0;
      sel     = '0;
      if (lock_q) begin
         sel_vld = rdy_vec[lock_id_q];
         sel     = lock_id_q;
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (rdy_vec[2'(disp_ptr_q + 2'(i))]) begin
               sel_vld = 1'b1;
               sel     = 2'(disp_ptr_q + 2'(i));
            end
         end
      end
   end

   assign hs             = sel_vld & bus.disp_ready;
   assign bus.disp_valid = sel_vld;
   assign bus.disp_ocid  = sel_vld ? sel : 2'd0;
   assign bus.disp_instr = sel_vld ? instr_q[sel] : '0;
   assign bus.disp_warp  = sel_vld ? warp_q[sel] : '0;
   assign bus.disp_op_a  = sel_vld ? opnd_q[{sel, 1'b0}] : '0;
   assign bus.disp_op_b  = sel_vld ? opnd_q[{sel, 1'b1}] : '0;
   assign bus.oc_empty   = {st_q[3] == StEmpty, st_q[2] == StEmpty,
                            st_q[1] == StEmpty, st_q[0] == StEmpty};
   assign bus.alloc_err  = alloc_err_q;

   always_comb begin
      st_d        = st_q;
      instr_d     = instr_q;
      warp_d      = warp_q;
      needed_d    = needed_q;
      in_flight_d = in_flight_q;
      captured_d  = captured_q;
      bank_d      = bank_q;
      row_d       = row_q;
      opnd_d      = opnd_q;
      arb_ptr_d   = arb_ptr_q;
      tag_vld_d   = gnt_vld;
      tag_d       = gnt_idx;
      disp_ptr_d  = disp_ptr_q;
      lock_d      = lock_q;
      lock_id_d   = lock_id_q;
      alloc_err_d = 1'b0;

      for (int k = 0; k < 4; k++) begin
         if (tag_vld_q[k]) begin
            opnd_d[tag_q[k]]      = bus.bank_rd_data[k*DATA_W +: DATA_W];
            captured_d[tag_q[k]]  = 1'b1;
            in_flight_d[tag_q[k]] = 1'b0;
         end
         if (gnt_vld[k]) begin
            in_flight_d[gnt_idx[k]] = 1'b1;
            arb_ptr_d[k]            = gnt_idx[k] + 3'd1;
         end
      end

      // Entries become READY on the same edge the last operand lands.
      for (int o = 0; o < 4; o++) begin
         case (st_q[o])
            StCollect: begin
               if (captured_d[2*o] && captured_d[2*o+1]) begin
                  st_d[o] = StReady;
               end
            end
            StReady: begin
               if (hs && (sel == 2'(o))) begin
                  st_d[o]          = StEmpty;
                  needed_d[2*o]    = 1'b0;
                  needed_d[2*o+1]  = 1'b0;
               end
            end
            default: ;
         endcase
      end

      if (hs) begin
         disp_ptr_d = sel + 2'd1;
         lock_d     = 1'b0;
      end else if (sel_vld) begin
         lock_d    = 1'b1;
         lock_id_d = sel;
      end

      if (bus.alloc_valid) begin
         if (st_q[bus.alloc_ocid] == StEmpty) begin
            st_d[bus.alloc_ocid]    = StCollect;
            instr_d[bus.alloc_ocid] = bus.alloc_instr;
            warp_d[bus.alloc_ocid]  = bus.alloc_warp;
            needed_d[slot_a]        = 1'b1;
            in_flight_d[slot_a]     = 1'b0;
            captured_d[slot_a]      = 1'b0;
            bank_d[slot_a]          = bus.alloc_bank_a;
            row_d[slot_a]           = bus.alloc_row_a;
            opnd_d[slot_a]          = '0;
            needed_d[slot_b]        = bus.alloc_two_op;
            in_flight_d[slot_b]     = 1'b0;
            captured_d[slot_b]      = ~bus.alloc_two_op;
            bank_d[slot_b]          = bus.alloc_bank_b;
            row_d[slot_b]           = bus.alloc_row_b;
            opnd_d[slot_b]          = '0;
         end else begin
            alloc_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int o = 0; o < 4; o++) begin
            st_q[o]      <= StEmpty;
            instr_q[o]   <= '0;
            warp_q[o]    <= '0;
         end
         for (int s = 0; s < 8; s++) begin
            bank_q[s]    <= '0;
            row_q[s]     <= '0;
            opnd_q[s]    <= '0;
         end
         for (int k = 0; k < 4; k++) begin
            arb_ptr_q[k] <= '0;
            tag_q[k]     <= '0;
         end
         needed_q    <= '0;
         in_flight_q <= '0;
         captured_q  <= '0;
         tag_vld_q   <= '0;
         disp_ptr_q  <= '0;
         lock_q      <= 1'b0;
         lock_id_q   <= '0;
         alloc_err_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         instr_q     <= instr_d;
         warp_q      <= warp_d;
         bank_q      <= bank_d;
         row_q       <= row_d;
         opnd_q      <= opnd_d;
         arb_ptr_q   <= arb_ptr_d;
         tag_q       <= tag_d;
         needed_q    <= needed_d;
         in_flight_q <= in_flight_d;
         captured_q  <= captured_d;
         tag_vld_q   <= tag_vld_d;
         disp_ptr_q  <= disp_ptr_d;
         lock_q      <= lock_d;
         lock_id_q   <= lock_id_d;
         alloc_err_q <= alloc_err_d;
      end
   end

endmodule

// File: tb/tb_operand_collector_array.sv
// Directed bench for operand_collector_array: a transaction-level model is compared on
// every falling edge, and hand-computed literals pin the key scenarios.
module tb_operand_collector_array;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   operand_collector_array_if #(.DATA_W(32), .ROW_W(3)) bus ();

   operand_collector_array #(.DATA_W(32), .ROW_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   logic [31:0] mem [4][8];
   logic [3:0]  rsp_en;
   logic [11:0] rsp_row;

   // Model: which entries hold work, which operand reads are still owed, what was read.
   bit          m_busy  [4];
   logic [31:0] m_instr [4];
   int          m_warp  [4];
   bit          m_want  [8];
   bit          m_have  [8];
   logic [31:0] m_val   [8];
   int          m_bank  [8];
   int          m_row   [8];
   int          m_ret   [4];
   int          m_rr    [4];
   int          m_dptr;
   int          m_lock;
   bit          m_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int bank_winner(input int k);
      int s;
      for (int i = 0; i < 8; i++) begin
         s = (m_rr[k] + i) % 8;
         if (m_want[s] && m_bank[s] == k) return s;
      end
      return -1;
   endfunction

   function automatic int disp_pick();
      int o;
      if (m_lock >= 0) return m_lock;
      for (int i = 0; i < 4; i++) begin
         o = (m_dptr + i) % 4;
         if (m_busy[o] && m_have[2*o] && m_have[2*o+1]) return o;
      end
      return -1;
   endfunction

   task automatic model_step();
      int win [4];
      int pick;
      bit hs;
      bit busy_pre [4];
      int oc, sa, sb;
      if (rst) begin
         for (int o = 0; o < 4; o++) begin
            m_busy[o] = 1'b0; m_instr[o] = '0; m_warp[o] = 0;
         end
         for (int s = 0; s < 8; s++) begin
            m_want[s] = 1'b0; m_have[s] = 1'b0; m_val[s] = '0; m_bank[s] = 0; m_row[s] = 0;
         end
         for (int k = 0; k < 4; k++) begin
            m_rr[k] = 0; m_ret[k] = -1;
         end
         m_dptr = 0; m_lock = -1; m_err = 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) win[k] = bank_winner(k);
         pick = disp_pick();
         hs = (pick >= 0) && bus.disp_ready;
         busy_pre = m_busy;
         for (int k = 0; k < 4; k++) begin
            if (m_ret[k] >= 0) begin
               m_val[m_ret[k]]  = bus.bank_rd_data[k*32 +: 32];
               m_have[m_ret[k]] = 1'b1;
            end
            m_ret[k] = win[k];
            if (win[k] >= 0) begin
               m_want[win[k]] = 1'b0;
               m_rr[k] = (win[k] + 1) % 8;
            end
         end
         if (hs) begin
            m_busy[pick] = 1'b0; m_dptr = (pick + 1) % 4; m_lock = -1;
         end else if (pick >= 0) begin
            m_lock = pick;
         end
         oc = int'(bus.alloc_ocid);
         m_err = bus.alloc_valid && busy_pre[oc];
         if (bus.alloc_valid && !busy_pre[oc]) begin
            sa = 2*oc; sb = 2*oc + 1;
            m_busy[oc] = 1'b1; m_instr[oc] = bus.alloc_instr; m_warp[oc] = int'(bus.alloc_warp);
            m_want[sa] = 1'b1; m_have[sa] = 1'b0; m_val[sa] = '0;
            m_bank[sa] = int'(bus.alloc_bank_a); m_row[sa] = int'(bus.alloc_row_a);
            m_want[sb] = bus.alloc_two_op; m_have[sb] = ~bus.alloc_two_op; m_val[sb] = '0;
            m_bank[sb] = int'(bus.alloc_bank_b); m_row[sb] = int'(bus.alloc_row_b);
         end
      end
   endtask

   task automatic compare();
      int w;
      int p;
      logic [3:0] exp_en;
      logic [3:0] exp_empty;
      for (int o = 0; o < 4; o++) exp_empty[o] = ~m_busy[o];
      chk("oc_empty", 64'(bus.oc_empty), 64'(exp_empty));
      chk("alloc_err", 64'(bus.alloc_err), 64'(m_err));
      for (int k = 0; k < 4; k++) begin
         w = bank_winner(k);
         exp_en[k] = (w >= 0);
         if (w >= 0) chk("bank_rd_row", 64'(bus.bank_rd_row[k*3 +: 3]), 64'(m_row[w]));
      end
      chk("bank_rd_en", 64'(bus.bank_rd_en), 64'(exp_en));
      p = disp_pick();
      chk("disp_valid", 64'(bus.disp_valid), 64'(p >= 0));
      if (p >= 0) begin
         chk("disp_ocid", 64'(bus.disp_ocid), 64'(p));
         chk("disp_instr", 64'(bus.disp_instr), 64'(m_instr[p]));
         chk("disp_warp", 64'(bus.disp_warp), 64'(m_warp[p]));
         chk("disp_op_a", 64'(bus.disp_op_a), 64'(m_val[2*p]));
         chk("disp_op_b", 64'(bus.disp_op_b), 64'(m_val[2*p+1]));
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) compare();
   end

   // Advance one cycle; bank data for reads issued this cycle appears in the next one.
   task automatic cyc();
      @(negedge clk);
      rsp_en  = bus.bank_rd_en;
      rsp_row = bus.bank_rd_row;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         bus.bank_rd_data[k*32 +: 32] = rsp_en[k] ? mem[k][rsp_row[k*3 +: 3]]
                                                  : (32'hBAD0_0000 | 32'(k));
      end
   endtask

   task automatic set_alloc(input int oc, input logic [31:0] ins, input int wp, input bit two,
                            input int ba, input int ra, input int bb, input int rb);
      bus.alloc_valid  = 1'b1;
      bus.alloc_ocid   = 2'(oc);
      bus.alloc_instr  = ins;
      bus.alloc_warp   = 3'(wp);
      bus.alloc_two_op = two;
      bus.alloc_bank_a = 2'(ba);
      bus.alloc_row_a  = 3'(ra);
      bus.alloc_bank_b = 2'(bb);
      bus.alloc_row_b  = 3'(rb);
   endtask

   initial begin
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < 8; r++) mem[k][r] = {8'h10, 8'(k), 8'h00, 8'(r)};
      bus.alloc_valid = 1'b0; bus.alloc_ocid = '0; bus.alloc_instr = '0; bus.alloc_warp = '0;
      bus.alloc_two_op = 1'b0; bus.alloc_bank_a = '0; bus.alloc_bank_b = '0;
      bus.alloc_row_a = '0; bus.alloc_row_b = '0; bus.bank_rd_data = '0; bus.disp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      chk_on = 1'b1;
      chk("rst_empty", 64'(bus.oc_empty), 64'hF);
      chk("rst_rd_en", 64'(bus.bank_rd_en), 64'h0);
      chk("rst_valid", 64'(bus.disp_valid), 64'h0);
      chk("rst_err", 64'(bus.alloc_err), 64'h0);
      chk("rst_op_a", 64'(bus.disp_op_a), 64'h0);

      // Single uncontended allocation
      bus.disp_ready = 1'b1;
      mem[1][2] = 32'hA1; mem[2][5] = 32'hB2;
      set_alloc(0, 32'hC0DE_0001, 5, 1'b1, 1, 2, 2, 5);
      cyc(); bus.alloc_valid = 1'b0;
      chk("t1_rd_en", 64'(bus.bank_rd_en), 64'b0110);
      chk("t1_empty", 64'(bus.oc_empty), 64'b1110);
      cyc(); cyc();
      chk("t1_valid", 64'(bus.disp_valid), 64'h1);
      chk("t1_ocid", 64'(bus.disp_ocid), 64'h0);
      chk("t1_op_a", 64'(bus.disp_op_a), 64'hA1);
      chk("t1_op_b", 64'(bus.disp_op_b), 64'hB2);
      cyc();
      chk("t1_empty_after", 64'(bus.oc_empty[0]), 64'h1);

      // Four reads contending for bank 3
      mem[3][1] = 32'h301; mem[3][4] = 32'h304; mem[3][6] = 32'h306; mem[3][7] = 32'h307;
      set_alloc(0, 32'h2000_0000, 1, 1'b1, 3, 1, 3, 4);
      cyc();
      set_alloc(1, 32'h2000_0001, 2, 1'b1, 3, 6, 3, 7);
      chk("t2_en_c1", 64'(bus.bank_rd_en[3]), 64'h1);
      chk("t2_row_c1", 64'(bus.bank_rd_row[11:9]), 64'd1);
      cyc(); bus.alloc_valid = 1'b0;
      chk("t2_row_c2", 64'(bus.bank_rd_row[11:9]), 64'd4);
      cyc();
      chk("t2_row_c3", 64'(bus.bank_rd_row[11:9]), 64'd6);
      cyc();
      chk("t2_row_c4", 64'(bus.bank_rd_row[11:9]), 64'd7);
      chk("t2_oc0_ocid", 64'(bus.disp_ocid), 64'h0);
      chk("t2_oc0_a", 64'(bus.disp_op_a), 64'h301);
      chk("t2_oc0_b", 64'(bus.disp_op_b), 64'h304);
      cyc(); cyc();
      chk("t2_oc1_ocid", 64'(bus.disp_ocid), 64'h1);
      chk("t2_oc1_a", 64'(bus.disp_op_a), 64'h306);
      chk("t2_oc1_b", 64'(bus.disp_op_b), 64'h307);
      cyc();

      // Back-pressure with two READY entries
      bus.disp_ready = 1'b0;
      set_alloc(3, 32'h3000_0003, 3, 1'b1, 0, 2, 1, 3);
      cyc();
      set_alloc(2, 32'h3000_0002, 4, 1'b1, 2, 0, 3, 0);
      cyc(); bus.alloc_valid = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_ocid", 64'(bus.disp_ocid), 64'h3);
         chk("t3_hold_a", 64'(bus.disp_op_a), 64'h1000_0002);
         chk("t3_hold_b", 64'(bus.disp_op_b), 64'h1001_0003);
         cyc();
      end
      bus.disp_ready = 1'b1;
      chk("t3_last_ocid", 64'(bus.disp_ocid), 64'h3);
      cyc();
      chk("t3_next_valid", 64'(bus.disp_valid), 64'h1);
      chk("t3_next_ocid", 64'(bus.disp_ocid), 64'h2);
      chk("t3_next_b", 64'(bus.disp_op_b), 64'h1003_0000);
      cyc();

      // Allocation to a busy collector, and to one dispatching in the same cycle
      bus.disp_ready = 1'b0;
      set_alloc(1, 32'h1111, 6, 1'b1, 0, 5, 0, 6);
      cyc();
      set_alloc(1, 32'h2222, 7, 1'b1, 1, 0, 2, 0);
      cyc(); bus.alloc_valid = 1'b0;
      chk("t4_err", 64'(bus.alloc_err), 64'h1);
      cyc();
      chk("t4_err_clr", 64'(bus.alloc_err), 64'h0);
      cyc();
      chk("t4_instr", 64'(bus.disp_instr), 64'h1111);
      chk("t4_warp", 64'(bus.disp_warp), 64'd6);
      chk("t4_op_a", 64'(bus.disp_op_a), 64'h1000_0005);
      bus.disp_ready = 1'b1;
      set_alloc(1, 32'h3333, 0, 1'b0, 0, 0, 0, 0);
      cyc(); bus.alloc_valid = 1'b0;
      chk("t4_same_err", 64'(bus.alloc_err), 64'h1);
      chk("t4_same_empty", 64'(bus.oc_empty), 64'hF);
      cyc();

      // Single-operand allocation
      set_alloc(0, 32'h5555, 2, 1'b0, 2, 3, 1, 1);
      cyc(); bus.alloc_valid = 1'b0;
      chk("t5_rd_en", 64'(bus.bank_rd_en), 64'b0100);
      chk("t5_row", 64'(bus.bank_rd_row[8:6]), 64'd3);
      cyc();
      chk("t5_rd_en_c2", 64'(bus.bank_rd_en), 64'h0);
      cyc();
      chk("t5_valid", 64'(bus.disp_valid), 64'h1);
      chk("t5_op_a", 64'(bus.disp_op_a), 64'h1002_0003);
      chk("t5_op_b", 64'(bus.disp_op_b), 64'h0);
      cyc();

      // Reset while bank reads are outstanding
      set_alloc(2, 32'h6666, 1, 1'b1, 1, 4, 1, 5);
      cyc(); bus.alloc_valid = 1'b0;
      chk("t6_rd_en", 64'(bus.bank_rd_en), 64'b0010);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t6_empty", 64'(bus.oc_empty), 64'hF);
      chk("t6_valid", 64'(bus.disp_valid), 64'h0);
      chk("t6_rd_en_clr", 64'(bus.bank_rd_en), 64'h0);
      chk("t6_op_a", 64'(bus.disp_op_a), 64'h0);
      repeat (4) begin
         cyc();
         chk("t6_no_stale", 64'(bus.disp_valid), 64'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
